// File: rtl/shape_pkg.sv
// Shared definitions for the shape scheduler: FSM state encoding and the
// record type value that marks an unused shape slot.
package shape_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        WAIT_START = 3'd2,
        WAIT_READ  = 3'd3,
        PRESENT    = 3'd4,
        DONE       = 3'd5
    } state_t;

    localparam int TY_EMPTY = 0;

endpackage

// File: rtl/shape_scheduler.sv
// Walks shape slots 0..count-1 once per frame: fetches each record from an
// external reader, drops empty slots, and hands the rest to the drawer.
module shape_scheduler
    import shape_pkg::*;
#(
    parameter int CORDW = 10,
    parameter int DATAW = 12,
    parameter int NUMW  = DATAW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic [NUMW-1:0]  shape_count,
    output logic [NUMW-1:0]  rd_id,
    output logic             rd_trigger,
    input  logic             rd_busy,
    input  logic [DATAW-1:0] rd_ty,
    input  logic [DATAW-1:0] rd_size,
    input  logic [DATAW-1:0] rd_rotate,
    input  logic [CORDW-1:0] rd_x,
    input  logic [CORDW-1:0] rd_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NUMW-1:0]  out_id,
    output logic [DATAW-1:0] out_ty,
    output logic [DATAW-1:0] out_size,
    output logic [DATAW-1:0] out_rotate,
    output logic [CORDW-1:0] out_x,
    output logic [CORDW-1:0] out_y,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun
);

    state_t            r_state;
    state_t            w_next;
    logic [NUMW-1:0]   r_count;
    logic [NUMW-1:0]   r_cur_id;
    logic [NUMW-1:0]   r_rd_id;
    logic              r_rd_trigger;
    logic              r_out_valid;
    logic              r_frame_done;
    logic              r_overrun;
    logic [NUMW-1:0]   r_out_id;
    logic [DATAW-1:0]  r_out_ty;
    logic [DATAW-1:0]  r_out_size;
    logic [DATAW-1:0]  r_out_rotate;
    logic [CORDW-1:0]  r_out_x;
    logic [CORDW-1:0]  r_out_y;

    logic              w_last;
    logic              w_capture;
    logic              w_empty;
    logic              w_transfer;
    logic              w_advance;

    // count is non-zero whenever this is consulted, so count-1 never wraps
    assign w_last     = (r_cur_id == (r_count - NUMW'(1)));
    assign w_capture  = (r_state == WAIT_READ) && !rd_busy;
    assign w_empty    = (rd_ty == DATAW'(TY_EMPTY));
    assign w_transfer = (r_state == PRESENT) && r_out_valid && out_ready;
    assign w_advance  = (w_capture && w_empty) || w_transfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (frame_start) begin
                    w_next = (shape_count == '0) ? DONE : ISSUE;
                end
            end
            ISSUE:      w_next = WAIT_START;
            WAIT_START: begin
                if (rd_busy) begin
                    w_next = WAIT_READ;
                end
            end
            WAIT_READ: begin
                if (!rd_busy) begin
                    if (!w_empty) begin
                        w_next = PRESENT;
                    end else begin
                        w_next = w_last ? DONE : ISSUE;
                    end
                end
            end
            PRESENT: begin
                if (w_transfer) begin
                    w_next = w_last ? DONE : ISSUE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Strobes are registered, which puts the first trigger two cycles
    // after frame_start and frame_done the cycle after DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count      <= '0;
            r_cur_id     <= '0;
            r_rd_id      <= '0;
            r_rd_trigger <= 1'b0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_out_id     <= '0;
            r_out_ty     <= '0;
            r_out_size   <= '0;
            r_out_rotate <= '0;
            r_out_x      <= '0;
            r_out_y      <= '0;
        end else begin
            r_rd_trigger <= (r_state == ISSUE);
            r_frame_done <= (r_state == DONE);

            if (frame_start && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end

            if ((r_state == IDLE) && frame_start) begin
                r_count  <= shape_count;
                r_cur_id <= '0;
            end else if (w_advance && !w_last) begin
                r_cur_id <= r_cur_id + NUMW'(1);
            end

            if (r_state == ISSUE) begin
                r_rd_id <= r_cur_id;
            end

            if (w_capture) begin
                r_out_id     <= r_cur_id;
                r_out_ty     <= rd_ty;
                r_out_size   <= rd_size;
                r_out_rotate <= rd_rotate;
                r_out_x      <= rd_x;
                r_out_y      <= rd_y;
                r_out_valid  <= !w_empty;
            end else if (w_transfer) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign busy       = (r_state != IDLE);
    assign rd_id      = r_rd_id;
    assign rd_trigger = r_rd_trigger;
    assign out_valid  = r_out_valid;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;
    assign out_id     = r_out_id;
    assign out_ty     = r_out_ty;
    assign out_size   = r_out_size;
    assign out_rotate = r_out_rotate;
    assign out_x      = r_out_x;
    assign out_y      = r_out_y;

endmodule

// File: tb/tb_shape_scheduler.sv
// Scoreboard bench for shape_scheduler: a behavioural record reader answers
// fetches, expected records are queued at frame start and checked by a monitor.
module tb_shape_scheduler;

    localparam int CORDW = 10;
    localparam int DATAW = 12;
    localparam int NUMW  = 12;

    logic             clk;
    logic             rst_n;
    logic             frame_start;
    logic [NUMW-1:0]  shape_count;
    logic [NUMW-1:0]  rd_id;
    logic             rd_trigger;
    logic             rd_busy;
    logic [DATAW-1:0] rd_ty, rd_size, rd_rotate;
    logic [CORDW-1:0] rd_x, rd_y;
    logic             out_valid;
    logic             out_ready;
    logic [NUMW-1:0]  out_id;
    logic [DATAW-1:0] out_ty, out_size, out_rotate;
    logic [CORDW-1:0] out_x, out_y;
    logic             busy;
    logic             frame_done;
    logic             overrun;

    typedef struct {
        logic [NUMW-1:0]  id;
        logic [DATAW-1:0] ty;
        logic [DATAW-1:0] size;
        logic [DATAW-1:0] rot;
        logic [CORDW-1:0] x;
        logic [CORDW-1:0] y;
    } exp_t;

    exp_t             exp_q[$];
    logic [DATAW-1:0] ty_tab[16];
    int               checks   = 0;
    int               failures = 0;
    int               done_cnt = 0;
    int               trig_cnt = 0;

    shape_scheduler #(.CORDW(CORDW), .DATAW(DATAW), .NUMW(NUMW)) dut (
        .clk(clk), .rst_n(rst_n),
        .frame_start(frame_start), .shape_count(shape_count),
        .rd_id(rd_id), .rd_trigger(rd_trigger), .rd_busy(rd_busy),
        .rd_ty(rd_ty), .rd_size(rd_size), .rd_rotate(rd_rotate),
        .rd_x(rd_x), .rd_y(rd_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_ty(out_ty), .out_size(out_size),
        .out_rotate(out_rotate), .out_x(out_x), .out_y(out_y),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATAW-1:0] f_size(input int id); return DATAW'(id * 3 + 5); endfunction
    function automatic logic [DATAW-1:0] f_rot(input int id);  return DATAW'(id + 100);    endfunction
    function automatic logic [CORDW-1:0] f_x(input int id);    return CORDW'(id * 7 + 1);  endfunction
    function automatic logic [CORDW-1:0] f_y(input int id);    return CORDW'(500 - id);    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int id);
        exp_t e;
        e.id = NUMW'(id); e.ty = ty_tab[id]; e.size = f_size(id);
        e.rot = f_rot(id); e.x = f_x(id); e.y = f_y(id);
        exp_q.push_back(e);
    endtask

    task automatic start_frame(input int count);
        @(posedge clk); #1;
        frame_start = 1'b1;
        shape_count = NUMW'(count);
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done_seen", done_cnt, target);
        repeat (10) @(negedge clk);
        chk("frame_done_once", done_cnt, target);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_timeout", out_valid, 1);
    endtask

    // Behavioural record reader: busy the cycle after a trigger, record at fall
    initial begin
        int fid, lat;
        rd_busy = 0; rd_ty = '0; rd_size = '0; rd_rotate = '0; rd_x = '0; rd_y = '0;
        forever begin
            @(negedge clk);
            if (rd_trigger === 1'b1) begin
                trig_cnt++;
                fid = int'(rd_id);
                lat = 1 + fid % 3;
                @(posedge clk); #1;
                rd_busy = 1'b1;
                repeat (lat) @(posedge clk);
                #1;
                chk("rd_id_stable", rd_id, fid);
                rd_busy   = 1'b0;
                rd_ty     = ty_tab[fid];
                rd_size   = f_size(fid);
                rd_rotate = f_rot(fid);
                rd_x      = f_x(fid);
                rd_y      = f_y(fid);
                if (ty_tab[fid] != '0) begin
                    @(negedge clk);
                    chk("valid_lat0", out_valid, 0);
                    @(negedge clk);
                    chk("valid_lat1", out_valid, 1);
                end
            end
        end
    end

    // Output monitor: one line per transfer, compared against the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                done_cnt++;
                chk("queue_empty_at_done", exp_q.size(), 0);
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got id %0d expected no transfer", out_id);
                end else begin
                    e = exp_q.pop_front();
                    $display("xfer id=%0d ty=%0d size=%0d rot=%0d x=%0d y=%0d", out_id, out_ty, out_size, out_rotate, out_x, out_y);
                    chk("out_id", out_id, e.id);
                    chk("out_ty", out_ty, e.ty);
                    chk("out_size", out_size, e.size);
                    chk("out_rotate", out_rotate, e.rot);
                    chk("out_x", out_x, e.x);
                    chk("out_y", out_y, e.y);
                end
            end
        end
    end

    initial begin
        int t0;
        logic [NUMW-1:0]  s_id;
        logic [DATAW-1:0] s_size;
        logic [CORDW-1:0] s_x;
        rst_n = 1'b0; frame_start = 1'b0; shape_count = '0; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) ty_tab[i] = 12'd1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rd_trigger", rd_trigger, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_rd_id", rd_id, 0);
        chk("rst_out_id", out_id, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Three full slots, drawer always ready; also trigger latency
        for (int i = 0; i < 3; i++) push_exp(i);
        t0 = trig_cnt;
        start_frame(3);
        @(negedge clk);
        chk("trig_lat_cycle1", rd_trigger, 0);
        chk("busy_running", busy, 1);
        @(negedge clk);
        chk("trig_lat_cycle2", rd_trigger, 1);
        chk("first_rd_id", rd_id, 0);
        wait_done(1);
        chk("trig_count_3", trig_cnt - t0, 3);
        chk("idle_after_pass", busy, 0);

        // Slot 1 empty: skipped but still fetched
        ty_tab[1] = 12'd0; ty_tab[2] = 12'd3; ty_tab[3] = 12'd2;
        push_exp(0); push_exp(2); push_exp(3);
        t0 = trig_cnt;
        start_frame(4);
        wait_done(2);
        chk("trig_count_4", trig_cnt - t0, 4);
        for (int i = 0; i < 16; i++) ty_tab[i] = 12'd1;

        // Drawer stalls for 5 cycles on the first record
        push_exp(0); push_exp(1);
        @(posedge clk); #1 out_ready = 1'b0;
        start_frame(2);
        wait_valid();
        s_id = out_id; s_size = out_size; s_x = out_x;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_id", out_id, s_id);
            chk("stall_size", out_size, s_size);
            chk("stall_x", out_x, s_x);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done(3);

        // Zero-count frame
        t0 = trig_cnt;
        start_frame(0);
        @(negedge clk);
        chk("zero_done_cycle1", frame_done, 0);
        @(negedge clk);
        chk("zero_done_cycle2", frame_done, 1);
        wait_done(4);
        chk("zero_no_trigger", trig_cnt - t0, 0);

        // frame_start during a fetch is ignored and flagged
        chk("overrun_before", overrun, 0);
        for (int i = 0; i < 3; i++) push_exp(i);
        start_frame(3);
        t0 = 0;
        while (rd_busy !== 1'b1 && t0 < 50) begin @(negedge clk); t0++; end
        chk("rd_busy_seen", rd_busy, 1);
        @(posedge clk); #1;
        frame_start = 1'b1; shape_count = '0;
        @(posedge clk); #1 frame_start = 1'b0;
        @(negedge clk);
        chk("overrun_set", overrun, 1);
        wait_done(5);
        chk("overrun_sticky", overrun, 1);

        // Reset while a record is being presented abandons the pass
        for (int i = 0; i < 3; i++) push_exp(i);
        @(posedge clk); #1 out_ready = 1'b0;
        start_frame(3);
        wait_valid();
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_rd_id", rd_id, 0);
        chk("mid_rst_out_id", out_id, 0);
        chk("mid_rst_out_size", out_size, 0);
        chk("mid_rst_out_x", out_x, 0);
        chk("mid_rst_frame_done", frame_done, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1; out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("no_done_after_rst", done_cnt, 5);

        // Fresh pass after reset restarts from id 0
        push_exp(0); push_exp(1);
        start_frame(2);
        wait_done(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
